// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a 2-entry {pc, inst} buffer.
//   Issues at most one instruction-memory request at a time, buffers the
//   returned words in address order, and flushes on a branch/jump redirect.
//
// state | meaning
// IDLE  | no request outstanding; issue one if the buffer has room
// WAIT  | request outstanding; the ack data will be pushed
// DROP  | request outstanding but killed by a redirect; ack data is dropped
//
// Ports:
//   clk_i          master clock, rising edge
//   clear_n_i      synchronous active-low reset
//   imem_req_o     one-cycle request pulse to instruction memory
//   imem_addr_o    fetch address (the PC register), word aligned
//   imem_ack_i     one-cycle response strobe from instruction memory
//   imem_data_i    instruction word, valid with imem_ack_i
//   if_valid_o     buffer head holds an instruction for ID
//   if_inst_o      instruction at buffer head
//   if_pc_o        address of instruction at buffer head
//   id_ready_i     ID accepts the head entry this cycle
//   redirect_i     one-cycle branch/jump redirect
//   redirect_pc_i  new fetch address when redirect_i is high
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        clear_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  input  logic        id_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, inst0_q, inst0_d;
  logic [31:0] pc1_q, pc1_d, inst1_q, inst1_d;
  logic        push, pop;
  logic [1:0]  count_after_pop;

  // Fetch control and PC update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req_o = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Requests are suppressed while reset is held so the bus stays quiet.
        if (!redirect_i && (count_q < 2'd2)) begin
          imem_req_o = clear_n_i;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          state_d = S_IDLE;
          push    = !redirect_i;
        end else if (redirect_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // A redirect keeps us here: the killed request is still in flight.
        if (imem_ack_i && !redirect_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Two-entry buffer; entry 0 is always the head, entry 1 shifts down on pop.
  assign pop             = (count_q != 2'd0) && id_ready_i && !redirect_i;
  assign count_after_pop = count_q - {1'b0, pop};

  always_comb begin
    count_d = count_q;
    pc0_d   = pc0_q;
    inst0_d = inst0_q;
    pc1_d   = pc1_q;
    inst1_d = inst1_q;
    if (redirect_i) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      if (push) begin
        if (count_after_pop == 2'd0) begin
          pc0_d   = pc_q;
          inst0_d = imem_data_i;
        end else begin
          pc1_d   = pc_q;
          inst1_d = imem_data_i;
        end
      end
      count_d = count_after_pop + {1'b0, push};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_n_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      pc0_q   <= 32'd0;
      inst0_q <= 32'd0;
      pc1_q   <= 32'd0;
      inst1_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      pc0_q   <= pc0_d;
      inst0_q <= inst0_d;
      pc1_q   <= pc1_d;
      inst1_q <= inst1_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign if_valid_o  = (count_q != 2'd0);
  assign if_inst_o   = inst0_q;
  assign if_pc_o     = pc0_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
//   A driver process plays instruction memory and the ID/redirect/reset
//   sources and keeps a reference model (fetch PC, outstanding request,
//   expected buffered instructions). A monitor process checks DUT outputs
//   on the falling edge and pops the expected queue on each ID handshake.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk),
    .clear_n_i     (clear_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_data_i   (imem_data),
    .if_valid_o    (if_valid),
    .if_inst_o     (if_inst),
    .if_pc_o       (if_pc),
    .id_ready_i    (id_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  int          due_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pops    = 0;
  int          reqs    = 0;
  int          cyc     = 0;
  bit          started = 1'b0;
  bit          prev_clr = 1'b0;

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_live;
  bit          req_s;

  // Stimulus knobs.
  int          p_ready    = 70;
  int          p_redir    = 0;
  int          p_rst      = 0;
  int          max_delay  = 0;
  bit          keep_stray = 1'b0;
  int          rst_hold   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare outputs against the model, then apply the upcoming edge's
  // pop/flush to the expected queue.
  always @(negedge clk) begin
    if (started) begin
      ent_t e;
      logic exp_req;
      exp_req = clear_n && !m_out && (exp_q.size() < 2) && !redirect;
      check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      check("imem_addr", imem_addr, m_pc);
      check("if_valid", {31'd0, if_valid}, {31'd0, exp_q.size() != 0});
      if (!prev_clr) begin
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
      end
      if (imem_req) reqs++;
      prev_clr = clear_n;
      if (!clear_n || redirect) begin
        exp_q.delete();
      end else if (if_valid && id_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_inst", if_inst, e.inst);
        pops++;
      end
    end
  end

  task automatic drive_inputs();
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      imem_ack  = 1'b1;
      imem_data = $urandom;
      void'(due_q.pop_front());
    end else begin
      imem_ack  = 1'b0;
      imem_data = $urandom;
    end
    id_ready = ($urandom_range(0, 99) < p_ready);
    // A redirect coinciding with the ack of an already-killed request would
    // leave the DUT waiting for an ack that never comes; avoid that pairing.
    redirect = ($urandom_range(0, 99) < p_redir) && !(imem_ack && m_out && !m_live);
    redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                : $urandom;
    if (rst_hold > 0) begin
      clear_n = 1'b0;
      rst_hold--;
    end else if ($urandom_range(0, 999) < p_rst * 10) begin
      clear_n  = 1'b0;
      rst_hold = $urandom_range(0, 1);
    end else begin
      clear_n = 1'b1;
    end
  endtask

  // Model update for the edge that just happened, using the inputs that were
  // held across it and the request seen in that cycle.
  task automatic apply_edge();
    int due;
    if (!clear_n) begin
      m_pc   = RST_PC;
      m_out  = 1'b0;
      m_live = 1'b0;
      if (!keep_stray) due_q.delete();
    end else begin
      if (m_out && imem_ack) begin
        if (m_live && !redirect) begin
          exp_q.push_back(ent_t'{m_pc, imem_data});
          m_pc = m_pc + 32'd4;
        end
        m_out = 1'b0;
      end
      if (redirect) begin
        m_pc   = {redirect_pc[31:2], 2'b00};
        m_live = 1'b0;
      end
      if (req_s) begin
        m_out  = 1'b1;
        m_live = 1'b1;
        due    = cyc + 1 + $urandom_range(0, max_delay);
        if (due_q.size() != 0 && due <= due_q[$]) due = due_q[$] + 1;
        due_q.push_back(due);
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      @(negedge clk);
      req_s = imem_req;
      @(posedge clk);
      apply_edge();
      #1;
    end
  endtask

  initial begin
    int p0;
    int r0;
    clear_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    id_ready    = 1'b0;
    imem_ack    = 1'b0;
    imem_data   = 32'd0;
    m_pc        = RST_PC;
    m_out       = 1'b0;
    m_live      = 1'b0;
    req_s       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    started = 1'b1;

    // Single-cycle memory, ID always ready: one instruction every 2 cycles,
    // addresses wrap FFFFFFF8, FFFFFFFC, 0, 4, 8 ...
    p_ready = 100; p_redir = 0; p_rst = 0; max_delay = 0;
    p0 = pops;
    run(40);
    check("throughput_pops", pops - p0, 32'd19);

    // ID stalled: the buffer fills to two entries and fetching stops.
    p_ready = 0;
    run(10);
    r0 = reqs;
    run(10);
    check("stall_no_req", reqs - r0, 32'd0);
    check("stall_full", {31'd0, if_valid}, 32'd1);
    p_ready = 100;
    run(12);

    // Mixed traffic with redirects, resets and variable memory latency.
    p_ready = 70; p_redir = 8; p_rst = 1; max_delay = 3;
    run(3000);

    // Resets that leave acks in flight, which later land as stray acks.
    keep_stray = 1'b1; p_rst = 5;
    run(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, fetch address after reset.
REQ-002 clk  input  1  master clock, all state updates on rising edge.
REQ-003 clear_n  input  1  reset, synchronous, active-low.
REQ-004 imem_req  output  1  one-cycle request pulse to instruction memory.
REQ-005 imem_addr  output  32  fetch address, equals internal PC register.
REQ-006 imem_ack  input  1  memory response strobe, one cycle, at least 1 cycle after imem_req.
REQ-007 imem_data  input  32  instruction word, valid when imem_ack=1.
REQ-008 if_valid  output  1  head of fetch buffer holds an instruction for ID.
REQ-009 if_inst  output  32  instruction at buffer head.
REQ-010 if_pc  output  32  address of instruction at buffer head.
REQ-011 id_ready  input  1  ID stage accepts head entry this cycle.
REQ-012 redirect  input  1  branch/jump redirect, one cycle.
REQ-013 redirect_pc  input  32  new fetch address when redirect=1.

Function
REQ-014 Block SHALL hold a 2-entry FIFO of {pc, inst} pairs, count 0..2; if_valid = (count != 0); if_inst/if_pc driven combinationally from head entry.
REQ-015 Pop SHALL occur when if_valid=1 and id_ready=1; push SHALL occur on an accepted response (REQ-018); simultaneous push and pop SHALL leave count unchanged with order preserved.
REQ-016 State machine SHALL have states IDLE, WAIT, DROP; at most one memory request outstanding.
REQ-017 IDLE: if count < 2 and redirect=0, assert imem_req for exactly that cycle with imem_addr = PC, go to WAIT; else stay IDLE with imem_req=0.
REQ-018 WAIT: on imem_ack=1 and redirect=0, push {PC, imem_data}, PC <= PC + 4 (modulo 2^32, wraps FFFFFFFC -> 00000000), go to IDLE; no ack: stay WAIT.
REQ-019 Redirect (any state) SHALL: empty FIFO (count <= 0, no pop counted), PC <= {redirect_pc[31:2], 2'b00}, discard any same-cycle imem_data.
REQ-020 Redirect state transitions: IDLE -> IDLE; WAIT with imem_ack=1 -> IDLE; WAIT with imem_ack=0 -> DROP; DROP -> DROP.
REQ-021 DROP: on imem_ack=1 discard data, no push, PC unchanged, go to IDLE.
REQ-022 imem_ack in IDLE SHALL be ignored (no push, no state change).
REQ-023 imem_req SHALL never assert in the same cycle as redirect=1 or while in WAIT/DROP.
REQ-024 imem_addr[1:0] SHALL always be 2'b00.
REQ-025 With single-cycle memory ack and id_ready=1 continuously, throughput SHALL be one instruction per 2 cycles; first if_valid SHALL rise 1 cycle after the ack edge.
REQ-026 Fetch order SHALL equal address order; no instruction SHALL be duplicated or skipped except by redirect.

Reset
REQ-027 When clear_n=0 at a rising edge: PC <= RESET_PC, state <= IDLE, count <= 0, FIFO storage <= 0.
REQ-028 Post-reset outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_inst=0, if_pc=0.
REQ-029 Reset SHALL take priority over redirect, imem_ack and id_ready in the same cycle.
REQ-030 Reset during WAIT or DROP SHALL abandon the outstanding request; a later stray imem_ack in IDLE follows REQ-022.

Verification
REQ-031 Reset, memory acks 1 cycle after each req, id_ready=1 -> ID sees pc/inst 0/mem[0], 4/mem[1], 8/mem[2] in order, imem_req every 2nd cycle.
REQ-032 id_ready=0 held -> exactly 2 entries buffered (pc 0, 4), imem_req stays 0; id_ready=1 -> entries drain in order, fetch resumes at pc 8.
REQ-033 Redirect to 32'h00000103 while in WAIT, ack arrives 3 cycles later -> ack data dropped, FIFO empty, next imem_req at addr 32'h00000100.
REQ-034 Redirect same cycle as imem_ack and pop -> nothing pushed, count=0, next state IDLE, next req at redirect address.
REQ-035 RESET_PC=32'hFFFFFFF8, two fetches -> pcs FFFFFFF8, FFFFFFFC, then imem_addr 00000000.
REQ-036 clear_n=0 during WAIT with stray ack in following IDLE cycle -> no push, if_valid=0, imem_addr=RESET_PC.
